or16_resp_checker: RTL and testbench

//  Receiving end of the 16-bit logic-gate stimulus sweep. Samples (A, B, OUT) vectors from a DUT such as
//  Or16, compares OUT against the expected gate result, and counts vectors and mismatches.

---
 rtl/or16_resp_checker_if.sv | 35 +++
 rtl/or16_resp_checker.sv | 103 ++++++++++
 tb/tb_or16_resp_checker.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/or16_resp_checker_if.sv
// Vector/result bus between a gate-sweep source and or16_resp_checker.
// Stimulus side drives i_*; the checker drives o_* back as registered status.
interface or16_resp_checker_if #(
    parameter int W     = 16,
    parameter int CNT_W = 32
);
    logic             i_start;
    logic [CNT_W-1:0] i_num_vecs;
    logic             i_in_vld;
    logic [W-1:0]     i_a;
    logic [W-1:0]     i_b;
    logic [W-1:0]     i_out;
    logic             o_busy;
    logic             o_done;
    logic             o_pass;
    logic [CNT_W-1:0] o_vec_cnt;
    logic [CNT_W-1:0] o_err_cnt;
    logic             o_fail_vld;
    logic [W-1:0]     o_fail_a;
    logic [W-1:0]     o_fail_b;
    logic [W-1:0]     o_fail_out;
    logic [W-1:0]     o_sig;

    modport master (
        output i_start, i_num_vecs, i_in_vld, i_a, i_b, i_out,
        input  o_busy, o_done, o_pass, o_vec_cnt, o_err_cnt,
        input  o_fail_vld, o_fail_a, o_fail_b, o_fail_out, o_sig
    );

    modport slave (
        input  i_start, i_num_vecs, i_in_vld, i_a, i_b, i_out,
        output o_busy, o_done, o_pass, o_vec_cnt, o_err_cnt,
        output o_fail_vld, o_fail_a, o_fail_b, o_fail_out, o_sig
    );
endinterface

// File: rtl/or16_resp_checker.sv
// Checks DUT gate results against OP(A,B), counts vectors/errors, keeps first failure and a MISR signature.
// Latency: 1 cycle, all outputs registered. Backpressure: none; every vector valid in RUN is consumed.
module or16_resp_checker #(
    parameter int           W     = 16,
    parameter int           CNT_W = 32,
    parameter int           OP    = 1,
    parameter logic [W-1:0] POLY  = 16'h1021,
    parameter logic [W-1:0] SEED  = 16'hFFFF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    or16_resp_checker_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_num_vecs;
    logic [CNT_W-1:0] r_vec_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic             r_pass;
    logic             r_fail_vld;
    logic [W-1:0]     r_fail_a;
    logic [W-1:0]     r_fail_b;
    logic [W-1:0]     r_fail_out;
    logic [W-1:0]     r_sig;

    logic [W-1:0]     w_exp;
    logic             w_accept;
    logic             w_mismatch;
    logic             w_finish;
    logic [CNT_W-1:0] w_vec_nxt;
    logic [CNT_W-1:0] w_err_nxt;
    logic [W-1:0]     w_sig_nxt;

    always_comb begin
        w_exp = bus.i_a | bus.i_b;
        case (OP)
            0:       w_exp = bus.i_a & bus.i_b;
            2:       w_exp = bus.i_a ^ bus.i_b;
            3:       w_exp = ~(bus.i_a & bus.i_b);
            default: w_exp = bus.i_a | bus.i_b;
        endcase
    end

    // An empty run (NUM_VECS==0) accepts nothing and simply finishes on its first RUN cycle.
    assign w_accept   = (r_state == S_RUN) && bus.i_in_vld && !bus.i_start && (r_num_vecs != '0);
    assign w_mismatch = w_accept && (bus.i_out != w_exp);
    assign w_vec_nxt  = r_vec_cnt + 1'b1;
    assign w_err_nxt  = (w_mismatch && (r_err_cnt != '1)) ? r_err_cnt + 1'b1 : r_err_cnt;
    assign w_sig_nxt  = ({r_sig[W-2:0], 1'b0} ^ (r_sig[W-1] ? POLY : '0)) ^ bus.i_out;
    assign w_finish   = (r_state == S_RUN) && !bus.i_start &&
                        ((r_num_vecs == '0) || (w_accept && (w_vec_nxt == r_num_vecs)));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.i_start)   w_state_nxt = S_RUN;
        else if (w_finish) w_state_nxt = S_DONE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || bus.i_start) begin
            r_num_vecs <= (!i_rst_n) ? '0 : bus.i_num_vecs;
            r_vec_cnt  <= '0;
            r_err_cnt  <= '0;
            r_pass     <= 1'b0;
            r_fail_vld <= 1'b0;
            r_fail_a   <= '0;
            r_fail_b   <= '0;
            r_fail_out <= '0;
            r_sig      <= SEED;
        end else begin
            if (w_accept) begin
                r_vec_cnt <= w_vec_nxt;
                r_err_cnt <= w_err_nxt;
                r_sig     <= w_sig_nxt;
                if (w_mismatch && !r_fail_vld) begin
                    r_fail_vld <= 1'b1;
                    r_fail_a   <= bus.i_a;
                    r_fail_b   <= bus.i_b;
                    r_fail_out <= bus.i_out;
                end
            end
            if (w_finish) r_pass <= (w_err_nxt == '0);
        end
    end

    assign bus.o_busy     = (r_state == S_RUN);
    assign bus.o_done     = (r_state == S_DONE);
    assign bus.o_pass     = r_pass;
    assign bus.o_vec_cnt  = r_vec_cnt;
    assign bus.o_err_cnt  = r_err_cnt;
    assign bus.o_fail_vld = r_fail_vld;
    assign bus.o_fail_a   = r_fail_a;
    assign bus.o_fail_b   = r_fail_b;
    assign bus.o_fail_out = r_fail_out;
    assign bus.o_sig      = r_sig;
endmodule

// File: tb/tb_or16_resp_checker.sv
// Bench for or16_resp_checker (OP=OR): directed scenarios plus a randomized run against a behavioural model.
module tb_or16_resp_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    or16_resp_checker_if #(.W(16), .CNT_W(32)) bus ();

    or16_resp_checker #(.W(16), .CNT_W(32), .OP(1), .POLY(16'h1021), .SEED(16'hFFFF)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: run phase 0=idle 1=running 2=finished
    int          m_st;
    logic [31:0] m_num, m_vec, m_err;
    bit          m_pass, m_fv;
    logic [15:0] m_fa, m_fb, m_fo, m_sig;

    // Signature step: multiply by x modulo the polynomial, then add the new word.
    function automatic logic [15:0] misr(logic [15:0] s, logic [15:0] d);
        int t;
        t = int'(s) * 2;
        if (t >= 65536) t = (t - 65536) ^ 'h1021;
        return 16'(t) ^ d;
    endfunction

    function automatic void m_step(bit r, bit st, logic [31:0] num, bit v,
                                   logic [15:0] a, logic [15:0] b, logic [15:0] o);
        if (!r || st) begin
            m_st = r ? 1 : 0; m_num = r ? num : 0; m_vec = 0; m_err = 0; m_pass = 0;
            m_fv = 0; m_fa = 0; m_fb = 0; m_fo = 0; m_sig = 16'hFFFF;
        end else if (m_st == 1) begin
            if (m_num == 0) begin
                m_st = 2; m_pass = 1;
            end else if (v) begin
                m_vec = m_vec + 1;
                if (o != (a | b)) begin
                    if (m_err != 32'hFFFF_FFFF) m_err = m_err + 1;
                    if (!m_fv) begin m_fv = 1; m_fa = a; m_fb = b; m_fo = o; end
                end
                m_sig = misr(m_sig, o);
                if (m_vec == m_num) begin m_st = 2; m_pass = (m_err == 0); end
            end
        end
    endfunction

    task automatic cyc();
        m_step(rst_n, bus.i_start, bus.i_num_vecs, bus.i_in_vld, bus.i_a, bus.i_b, bus.i_out);
        @(posedge clk); #1;
    endtask

    task automatic send(logic [15:0] a, logic [15:0] b, logic [15:0] o);
        bus.i_in_vld = 1; bus.i_a = a; bus.i_b = b; bus.i_out = o;
        cyc();
        bus.i_in_vld = 0;
    endtask

    task automatic start_run(logic [31:0] n);
        bus.i_start = 1; bus.i_num_vecs = n;
        cyc();
        bus.i_start = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; cyc(); cyc(); rst_n = 1;
        n_cmp++;
        if ({bus.o_busy, bus.o_done, bus.o_pass, bus.o_fail_vld} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags got %b want 0000", {bus.o_busy, bus.o_done, bus.o_pass, bus.o_fail_vld});
        end
        n_cmp++;
        if (bus.o_vec_cnt !== 0 || bus.o_err_cnt !== 0) begin
            n_bad++; $display("FAIL reset_cnt got vec=%0d err=%0d want 0/0", bus.o_vec_cnt, bus.o_err_cnt);
        end
        n_cmp++;
        if (bus.o_sig !== 16'hFFFF) begin n_bad++; $display("FAIL reset_sig got %h want ffff", bus.o_sig); end
    endtask

    task automatic test_clean_run();
        start_run(3);
        n_cmp++;
        if (bus.o_busy !== 1'b1 || bus.o_done !== 1'b0) begin
            n_bad++; $display("FAIL clean_busy got busy=%b done=%b want 1/0", bus.o_busy, bus.o_done);
        end
        send(16'h00F0, 16'h0F00, 16'h0FF0);
        send(16'hFFFF, 16'h0000, 16'hFFFF);
        n_cmp++;
        if (bus.o_done !== 1'b0 || bus.o_vec_cnt !== 2) begin
            n_bad++; $display("FAIL clean_mid got done=%b vec=%0d want 0/2", bus.o_done, bus.o_vec_cnt);
        end
        send(16'h0000, 16'h0000, 16'h0000);
        n_cmp++;
        if ({bus.o_done, bus.o_pass, bus.o_busy} !== 3'b110 || bus.o_vec_cnt !== 3 || bus.o_err_cnt !== 0) begin
            n_bad++; $display("FAIL clean_end got done=%b pass=%b busy=%b vec=%0d err=%0d want 1/1/0/3/0",
                              bus.o_done, bus.o_pass, bus.o_busy, bus.o_vec_cnt, bus.o_err_cnt);
        end
    endtask

    task automatic test_fault();
        start_run(2);
        send(16'h1234, 16'h0001, 16'h1235);
        send(16'h1234, 16'h0001, 16'h1234);
        send(16'h8000, 16'h0001, 16'h0000);
        n_cmp++;
        if (bus.o_err_cnt !== 1 || bus.o_vec_cnt !== 2 || bus.o_pass !== 1'b0 || bus.o_done !== 1'b1) begin
            n_bad++; $display("FAIL fault_cnt got err=%0d vec=%0d pass=%b done=%b want 1/2/0/1",
                              bus.o_err_cnt, bus.o_vec_cnt, bus.o_pass, bus.o_done);
        end
        n_cmp++;
        if (bus.o_fail_vld !== 1'b1 || bus.o_fail_a !== 16'h1234 || bus.o_fail_b !== 16'h0001 ||
            bus.o_fail_out !== 16'h1234) begin
            n_bad++; $display("FAIL fault_vec got v=%b a=%h b=%h o=%h want 1/1234/0001/1234",
                              bus.o_fail_vld, bus.o_fail_a, bus.o_fail_b, bus.o_fail_out);
        end
    endtask

    task automatic test_misr();
        start_run(1);
        send(16'h0000, 16'h0000, 16'h0000);
        n_cmp++;
        if (bus.o_sig !== 16'hEFDF || bus.o_pass !== 1'b1) begin
            n_bad++; $display("FAIL misr got sig=%h pass=%b want efdf/1", bus.o_sig, bus.o_pass);
        end
    endtask

    task automatic test_gaps();
        start_run(4);
        send(16'h0001, 16'h0002, 16'h0003);
        send(16'h0010, 16'h0020, 16'h0030);
        for (int i = 0; i < 5; i++) cyc();
        n_cmp++;
        if (bus.o_vec_cnt !== 2 || bus.o_busy !== 1'b1) begin
            n_bad++; $display("FAIL gap_hold got vec=%0d busy=%b want 2/1", bus.o_vec_cnt, bus.o_busy);
        end
        start_run(0);
        n_cmp++;
        if (bus.o_busy !== 1'b1 || bus.o_done !== 1'b0) begin
            n_bad++; $display("FAIL zero_start got busy=%b done=%b want 1/0", bus.o_busy, bus.o_done);
        end
        cyc();
        n_cmp++;
        if (bus.o_done !== 1'b1 || bus.o_pass !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_vec_cnt !== 0) begin
            n_bad++; $display("FAIL zero_done got done=%b pass=%b busy=%b vec=%0d want 1/1/0/0",
                              bus.o_done, bus.o_pass, bus.o_busy, bus.o_vec_cnt);
        end
    endtask

    task automatic test_restart();
        start_run(4);
        send(16'h0F0F, 16'h0000, 16'h0F0F);
        send(16'h0001, 16'h0000, 16'h0002);
        // restart coincides with a valid (bad) vector: the vector must be dropped
        bus.i_start = 1; bus.i_num_vecs = 4;
        send(16'h0001, 16'h0001, 16'hBEEF);
        bus.i_start = 0;
        n_cmp++;
        if (bus.o_vec_cnt !== 0 || bus.o_err_cnt !== 0 || bus.o_fail_vld !== 1'b0 || bus.o_busy !== 1'b1 ||
            bus.o_sig !== 16'hFFFF) begin
            n_bad++; $display("FAIL restart_clear got vec=%0d err=%0d fv=%b busy=%b sig=%h want 0/0/0/1/ffff",
                              bus.o_vec_cnt, bus.o_err_cnt, bus.o_fail_vld, bus.o_busy, bus.o_sig);
        end
        for (int i = 0; i < 3; i++) send(16'(i), 16'h0100, 16'(i) | 16'h0100);
        n_cmp++;
        if (bus.o_done !== 1'b0 || bus.o_vec_cnt !== 3) begin
            n_bad++; $display("FAIL restart_3 got done=%b vec=%0d want 0/3", bus.o_done, bus.o_vec_cnt);
        end
        send(16'h00AA, 16'h0055, 16'h00FF);
        n_cmp++;
        if (bus.o_done !== 1'b1 || bus.o_pass !== 1'b1 || bus.o_vec_cnt !== 4) begin
            n_bad++; $display("FAIL restart_4 got done=%b pass=%b vec=%0d want 1/1/4",
                              bus.o_done, bus.o_pass, bus.o_vec_cnt);
        end
        start_run(4);
        send(16'h0001, 16'h0000, 16'h0000);
        send(16'h0002, 16'h0000, 16'h0002);
        rst_n = 0; bus.i_in_vld = 1; bus.i_start = 1; cyc(); rst_n = 1; bus.i_in_vld = 0; bus.i_start = 0;
        n_cmp++;
        if (bus.o_vec_cnt !== 0 || bus.o_err_cnt !== 0 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 ||
            bus.o_fail_vld !== 1'b0 || bus.o_sig !== 16'hFFFF) begin
            n_bad++; $display("FAIL midrun_reset got vec=%0d err=%0d busy=%b done=%b fv=%b sig=%h",
                              bus.o_vec_cnt, bus.o_err_cnt, bus.o_busy, bus.o_done, bus.o_fail_vld, bus.o_sig);
        end
        send(16'h0003, 16'h0000, 16'h0003);
        n_cmp++;
        if (bus.o_vec_cnt !== 0 || bus.o_busy !== 1'b0) begin
            n_bad++; $display("FAIL idle_ignore got vec=%0d busy=%b want 0/0", bus.o_vec_cnt, bus.o_busy);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, o;
        for (int i = 0; i < 600; i++) begin
            rst_n          = ($urandom_range(0, 199) != 0);
            bus.i_start    = ($urandom_range(0, 24) == 0);
            bus.i_num_vecs = $urandom_range(0, 7);
            a = 16'($urandom); b = 16'($urandom);
            o = ($urandom_range(0, 3) == 0) ? ((a | b) ^ 16'($urandom_range(1, 65535))) : (a | b);
            bus.i_in_vld = ($urandom_range(0, 3) != 0);
            bus.i_a = a; bus.i_b = b; bus.i_out = o;
            cyc();
            n_cmp++;
            if (bus.o_busy !== (m_st == 1) || bus.o_done !== (m_st == 2) || bus.o_pass !== m_pass ||
                bus.o_vec_cnt !== m_vec || bus.o_err_cnt !== m_err || bus.o_fail_vld !== m_fv ||
                bus.o_fail_a !== m_fa || bus.o_fail_b !== m_fb || bus.o_fail_out !== m_fo ||
                bus.o_sig !== m_sig) begin
                n_bad++;
                $display("FAIL random[%0d] got b=%b d=%b p=%b v=%0d e=%0d fv=%b sig=%h want b=%b d=%b p=%b v=%0d e=%0d fv=%b sig=%h",
                         i, bus.o_busy, bus.o_done, bus.o_pass, bus.o_vec_cnt, bus.o_err_cnt, bus.o_fail_vld,
                         bus.o_sig, (m_st == 1), (m_st == 2), m_pass, m_vec, m_err, m_fv, m_sig);
            end
        end
        rst_n = 1; bus.i_start = 0; bus.i_in_vld = 0;
    endtask

    initial begin
        bus.i_start = 0; bus.i_num_vecs = 0; bus.i_in_vld = 0;
        bus.i_a = 0; bus.i_b = 0; bus.i_out = 0;
        #1;
        test_reset();
        test_clean_run();
        test_fault();
        test_misr();
        test_gaps();
        test_restart();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
